// File: rtl/sqrt_req_scheduler_pkg.sv
// Shared constants for the square-root request scheduler: FSM encodings
// and the default latency of the shared sqrt pipeline.
package sqrt_req_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam int DEFAULT_LATENCY = 5;

endpackage

// File: rtl/sqrt_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr
// (mod NREQ) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/sqrt_req_scheduler.sv
// Round-robin sharing of one fixed-latency sqrt pipeline among NREQ requesters,
// with a tag pipe that routes each result back and a drain/halt FSM.
module sqrt_req_scheduler
  import sqrt_req_scheduler_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int NREQ    = 4,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int IDW     = $clog2(NREQ),
  parameter int CW      = $clog2(LATENCY + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*BITSIZE-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [BITSIZE-1:0]      sq_data_in,
  input  logic [BITSIZE-1:0]      sq_data_out,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [BITSIZE-1:0]      rsp_data,
  input  logic                    drain,
  output logic                    idle,
  output logic [CW-1:0]           inflight,
  output logic [1:0]              dbg_state
);

  // Handshake: requester i transfers its operand in any cycle where
  // req_valid[i] & req_ready[i]; responses are unconditional one-cycle pulses.

  logic [IDW-1:0]                ptr_q, ptr_d;
  logic [LATENCY-1:0]            tag_v_q, tag_v_d;
  logic [LATENCY-1:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [CW-1:0]                 inflight_q, inflight_d;
  state_e                        state_q, state_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            accept;
  logic            issue;
  logic            retire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    accept     = (state_q == ST_ACTIVE) && !drain;
    issue      = accept && grant_any;
    retire     = tag_v_q[LATENCY-1];
    req_ready  = accept ? grant : '0;
    sq_data_in = issue ? req_data[int'(grant_id)*BITSIZE +: BITSIZE] : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
    end

    tag_v_d  = {tag_v_q[LATENCY-2:0], issue};
    tag_id_d = {tag_id_q[LATENCY-2:0], grant_id};

    inflight_d = inflight_q;
    if (issue && !retire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue && retire) begin
      inflight_d = inflight_q - CW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (drain) state_d = ST_DRAIN;
      // A retire this cycle means the counter is about to change; wait it out.
      ST_DRAIN:  if (inflight_q == '0 && !retire) state_d = ST_HALT;
      ST_HALT:   if (!drain) state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      inflight_q <= '0;
      state_q    <= ST_ACTIVE;
    end else begin
      ptr_q      <= ptr_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (retire) begin
      rsp_valid[tag_id_q[LATENCY-1]] = 1'b1;
    end
    rsp_data  = retire ? sq_data_out : '0;
    idle      = (state_q == ST_HALT);
    inflight  = inflight_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Directed bench for sqrt_req_scheduler with a behavioural 5-stage sqrt unit
// and a queue-based scoreboard checking every response's owner, data and cycle.
module tb_sqrt_req_scheduler;

  localparam int BITSIZE = 16;
  localparam int NREQ    = 4;
  localparam int LAT     = 5;
  localparam int CW      = 3;
  localparam int W       = 32 + 2 + 16;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*BITSIZE-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic [BITSIZE-1:0]      sq_data_in;
  logic [BITSIZE-1:0]      sq_data_out;
  logic [NREQ-1:0]         rsp_valid;
  logic [BITSIZE-1:0]      rsp_data;
  logic                    drain;
  logic                    idle;
  logic [CW-1:0]           inflight;
  logic [1:0]              dbg_state;

  int unsigned     cyc;
  int              n_chk;
  int              n_pass;
  logic [W-1:0]    exp_q[$];
  logic [15:0]     ops[4];
  logic [1:0]      m_ptr;
  logic [15:0]     sq_pipe[LAT];

  sqrt_req_scheduler #(
    .BITSIZE (BITSIZE),
    .NREQ    (NREQ),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .sq_data_in  (sq_data_in),
    .sq_data_out (sq_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .drain       (drain),
    .idle        (idle),
    .inflight    (inflight),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset-independent infrastructure ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden Q5.11 square root: floor(sqrt(x * 2^11)); negative operands give 0.
  function automatic logic [15:0] model_sqrt(input logic [15:0] x);
    logic [31:0] v;
    logic [31:0] r;
    logic [31:0] t;
    if (x[15]) return 16'h0000;
    v = {5'b0, x, 11'b0};
    r = 0;
    for (int b = 13; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[15:0];
  endfunction

  // Behavioural sqrt unit: samples data_in every edge, result LAT edges later.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) sq_pipe[i] <= 16'h0000;
    end else begin
      sq_pipe[0] <= model_sqrt(sq_data_in);
      for (int i = 1; i < LAT; i++) sq_pipe[i] <= sq_pipe[i-1];
    end
  end
  assign sq_data_out = sq_pipe[LAT-1];

  function automatic logic [3:0] rr_model(input logic [3:0] v, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(p) + k) % 4;
      if (v[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] v, input logic dr, input logic [3:0] exp_rdy);
    logic [1:0] id;
    @(negedge clk);
    req_valid = v;
    drain     = dr;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      id = oh2id(exp_rdy);
      chk("sq_data_in", 32'(sq_data_in), 32'(ops[id]));
      exp_q.push_back({cyc + LAT, id, model_sqrt(ops[id])});
      m_ptr = id + 2'd1;
    end else begin
      chk("sq_data_in_zero", 32'(sq_data_in), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b0000;
    drain     = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_ptr = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #2;
    if (exp_q.size() > 0 && e_due(exp_q[0]) == cyc) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e[17:16]));
      chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
    end else begin
      chk("rsp_quiet", 32'(rsp_valid), 32'd0);
    end
  end

  function automatic int unsigned e_due(input logic [W-1:0] e);
    return e[49:18];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_chk     = 0;
    n_pass    = 0;
    m_ptr     = 2'd0;
    reset     = 1'b1;
    drain     = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    for (int i = 0; i < 4; i++) ops[i] = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init_inflight", 32'(inflight), 32'd0);
    chk("init_idle", 32'(idle), 32'd0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 0, operand 0 -> result 0.
    drive(4'b0001, 1'b0, 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      drive(4'b0000, 1'b0, 4'b0000);
      chk("single_inflight", 32'(inflight), (k <= 5) ? 32'd1 : 32'd0);
    end

    // 4.0->2.0, 1.0->1.0, 0.25->0.5, 9.0->3.0
    ops[0] = 16'h2000; ops[1] = 16'h0800; ops[2] = 16'h0200; ops[3] = 16'h4800;
    drive(4'b1000, 1'b0, 4'b1000);            // moves ptr back to 0
    for (int k = 0; k < 8; k++) drive(4'b1111, 1'b0, 4'b0001 << (k % 4));

    // Only requesters 1 and 3 active.
    for (int k = 0; k < 6; k++) drive(4'b1010, 1'b0, (k % 2) ? 4'b1000 : 4'b0010);

    // Fill the pipe, then drain.
    for (int k = 0; k < 5; k++) drive(4'b1111, 1'b0, 4'b0001 << (k % 4));
    drive(4'b1111, 1'b1, 4'b0000);
    chk("drain_inflight_full", 32'(inflight), 32'd5);
    chk("drain_idle_t0", 32'(idle), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      drive(4'b1111, 1'b1, 4'b0000);
      if (k == 5) chk("drain_idle_t5", 32'(idle), 32'd0);
      if (k == 6) chk("drain_idle_t6", 32'(idle), 32'd1);
    end
    chk("halt_state", 32'(dbg_state), 32'd2);
    drive(4'b1111, 1'b0, 4'b0000);            // still HALT this cycle
    chk("halt_inflight", 32'(inflight), 32'd0);
    drive(4'b1111, 1'b0, 4'b0010);            // ACTIVE again, ptr=1
    chk("resume_idle", 32'(idle), 32'd0);
    for (int k = 0; k < 6; k++) drive(4'b0000, 1'b0, 4'b0000);

    // Reset in the middle of a burst.
    drive(4'b1111, 1'b0, 4'b0100);
    drive(4'b1111, 1'b0, 4'b1000);
    drive(4'b1111, 1'b0, 4'b0001);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0000, 1'b0, 4'b0000);
      chk("post_rst_inflight", 32'(inflight), 32'd0);
    end
    drive(4'b1111, 1'b0, 4'b0001);            // ptr was cleared

    // Full load: simultaneous issue and retire keep inflight at LATENCY.
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 1'b0, 4'b0001 << ((1 + k) % 4));
      if (k >= 5) chk("full_inflight", 32'(inflight), 32'd5);
    end

    // Random valid patterns and operands against the round-robin model.
    for (int k = 0; k < 100; k++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) ops[i] = 16'($urandom_range(0, 16'hffff));
      drive(v, 1'b0, rr_model(v, m_ptr));
    end

    for (int k = 0; k < 8; k++) drive(4'b0000, 1'b0, 4'b0000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_inflight", 32'(inflight), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
